// File: rtl/sap_pkg.sv
// Shared SAP definitions: opcodes, T-state encodings
// and the control-strobe bundle driven by the sequencer.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic pc_inc;
    logic pc_oe;
    logic pc_load;
    logic mar_write;
    logic ram_oe;
    logic ram_write;
    logic ir_write;
    logic ir_oe;
    logic a_write;
    logic a_oe;
    logic b_write;
    logic alu_oe;
    logic alu_sub;
    logic flag_write;
    logic out_write;
  } ctrl_t;

endpackage

// File: rtl/sap_cu_decode.sv
// Combinational strobe decoder: {state, opcode, zero_flag}
// -> ctrl strobes, fin (instruction ends), to_halt.
module sap_cu_decode
  import sap_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  input  logic       zero_flag,
  output ctrl_t      ctrl,
  output logic       fin,
  output logic       to_halt
);

  always_comb begin
    ctrl    = '0;
    fin     = 1'b0;
    to_halt = 1'b0;
    case (state)
      S_T0: begin
        ctrl.pc_oe     = 1'b1;
        ctrl.mar_write = 1'b1;
      end
      S_T1: begin
        ctrl.ram_oe   = 1'b1;
        ctrl.ir_write = 1'b1;
        ctrl.pc_inc   = 1'b1;
      end
      S_T2: begin
        unique case (1'b1)
          (op <= OP_STA): begin
            ctrl.ir_oe     = 1'b1;
            ctrl.mar_write = 1'b1;
          end
          (op == OP_LDI): begin
            ctrl.ir_oe   = 1'b1;
            ctrl.a_write = 1'b1;
            fin          = 1'b1;
          end
          (op == OP_JMP): begin
            ctrl.ir_oe   = 1'b1;
            ctrl.pc_load = 1'b1;
            fin          = 1'b1;
          end
          (op == OP_JZ): begin
            ctrl.ir_oe   = zero_flag;
            ctrl.pc_load = zero_flag;
            fin          = 1'b1;
          end
          (op == OP_OUT): begin
            ctrl.a_oe      = 1'b1;
            ctrl.out_write = 1'b1;
            fin            = 1'b1;
          end
          (op == OP_HLT): to_halt = 1'b1;
          default: fin = 1'b1;
        endcase
      end
      S_T3: begin
        case (op)
          OP_LDA: begin
            ctrl.ram_oe  = 1'b1;
            ctrl.a_write = 1'b1;
            fin          = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_oe  = 1'b1;
            ctrl.b_write = 1'b1;
          end
          OP_STA: begin
            ctrl.a_oe      = 1'b1;
            ctrl.ram_write = 1'b1;
            fin            = 1'b1;
          end
          default: fin = 1'b1;
        endcase
      end
      S_T4: begin
        ctrl.alu_oe     = 1'b1;
        ctrl.a_write    = 1'b1;
        ctrl.flag_write = 1'b1;
        ctrl.alu_sub    = (op == OP_SUB);
        fin             = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sap_control_unit.sv
// SAP sequencer: T-state register + next-state logic;
// strobes come from sap_cu_decode (Moore, unregistered).
module sap_control_unit
  import sap_pkg::*;
#(
  parameter int DW  = 16,
  parameter int OPW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [DW-1:0] ir_out,
  input  logic          zero_flag,
  output logic          pc_inc,
  output logic          pc_oe,
  output logic          pc_load,
  output logic          mar_write,
  output logic          ram_oe,
  output logic          ram_write,
  output logic          ir_write,
  output logic          ir_oe,
  output logic          a_write,
  output logic          a_oe,
  output logic          b_write,
  output logic          alu_oe,
  output logic          alu_sub,
  output logic          flag_write,
  output logic          out_write,
  output logic [2:0]    t_state,
  output logic          halted
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   fin;
  logic   to_halt;
  logic   unused_operand;

  // operand bits are routed by the IR, not used here
  assign unused_operand = ^ir_out[DW-OPW-1:0];

  sap_cu_decode u_dec (
    .state     (state),
    .op        (ir_out[DW-1:DW-OPW]),
    .zero_flag (zero_flag),
    .ctrl      (ctrl),
    .fin       (fin),
    .to_halt   (to_halt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: state_nxt = run ? S_T0 : S_IDLE;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2, S_T3, S_T4: begin
        if (to_halt)  state_nxt = S_HALT;
        else if (fin) state_nxt = run ? S_T0 : S_IDLE;
        else if (state == S_T2) state_nxt = S_T3;
        else          state_nxt = S_T4;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pc_inc     = ctrl.pc_inc;
  assign pc_oe      = ctrl.pc_oe;
  assign pc_load    = ctrl.pc_load;
  assign mar_write  = ctrl.mar_write;
  assign ram_oe     = ctrl.ram_oe;
  assign ram_write  = ctrl.ram_write;
  assign ir_write   = ctrl.ir_write;
  assign ir_oe      = ctrl.ir_oe;
  assign a_write    = ctrl.a_write;
  assign a_oe       = ctrl.a_oe;
  assign b_write    = ctrl.b_write;
  assign alu_oe     = ctrl.alu_oe;
  assign alu_sub    = ctrl.alu_sub;
  assign flag_write = ctrl.flag_write;
  assign out_write  = ctrl.out_write;
  assign t_state    = state;
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_sap_control_unit.sv
// Bench for sap_control_unit: instruction-level model
// plus directed literal checks and random programs.
module tb_sap_control_unit;

  localparam logic [14:0] PC_INC  = 15'h4000;
  localparam logic [14:0] PC_OE   = 15'h2000;
  localparam logic [14:0] PC_LD   = 15'h1000;
  localparam logic [14:0] MAR_W   = 15'h0800;
  localparam logic [14:0] RAM_OE  = 15'h0400;
  localparam logic [14:0] RAM_W   = 15'h0200;
  localparam logic [14:0] IR_W    = 15'h0100;
  localparam logic [14:0] IR_OE   = 15'h0080;
  localparam logic [14:0] A_W     = 15'h0040;
  localparam logic [14:0] A_OE    = 15'h0020;
  localparam logic [14:0] B_W     = 15'h0010;
  localparam logic [14:0] ALU_OE  = 15'h0008;
  localparam logic [14:0] ALU_SUB = 15'h0004;
  localparam logic [14:0] FLAG_W  = 15'h0002;
  localparam logic [14:0] OUT_W   = 15'h0001;

  logic        clk = 0;
  logic        rst;
  logic        run;
  logic [15:0] ir_out;
  logic        zero_flag;
  logic pc_inc, pc_oe, pc_load, mar_write, ram_oe;
  logic ram_write, ir_write, ir_oe, a_write, a_oe;
  logic b_write, alu_oe, alu_sub, flag_write, out_write;
  logic [2:0] t_state;
  logic       halted;

  int n_cmp = 0;
  int n_bad = 0;

  sap_control_unit dut (
    .clk(clk), .rst(rst), .run(run), .ir_out(ir_out),
    .zero_flag(zero_flag),
    .pc_inc(pc_inc), .pc_oe(pc_oe), .pc_load(pc_load),
    .mar_write(mar_write), .ram_oe(ram_oe),
    .ram_write(ram_write), .ir_write(ir_write),
    .ir_oe(ir_oe), .a_write(a_write), .a_oe(a_oe),
    .b_write(b_write), .alu_oe(alu_oe), .alu_sub(alu_sub),
    .flag_write(flag_write), .out_write(out_write),
    .t_state(t_state), .halted(halted)
  );

  always #5 clk = ~clk;

  wire [14:0] strobes = {pc_inc, pc_oe, pc_load, mar_write,
    ram_oe, ram_write, ir_write, ir_oe, a_write, a_oe,
    b_write, alu_oe, alu_sub, flag_write, out_write};

  task automatic chk(input string nm, input int got,
                     input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // --- instruction-level reference model ---
  function automatic int ilen(input logic [3:0] op);
    if (op == 4'h1 || op == 4'h2) return 5;
    if (op == 4'h0 || op == 4'h3) return 4;
    return 3;
  endfunction

  function automatic logic [14:0] exp_vec(input int k,
    input logic [3:0] op, input logic z);
    case (k)
      0: return PC_OE | MAR_W;
      1: return RAM_OE | IR_W | PC_INC;
      2: begin
        if (op <= 4'h3) return IR_OE | MAR_W;
        if (op == 4'h4) return IR_OE | A_W;
        if (op == 4'h5) return IR_OE | PC_LD;
        if (op == 4'h6) return z ? (IR_OE | PC_LD) : 15'h0;
        if (op == 4'hE) return A_OE | OUT_W;
        return 15'h0;
      end
      3: begin
        if (op == 4'h0) return RAM_OE | A_W;
        if (op == 4'h3) return A_OE | RAM_W;
        return RAM_OE | B_W;
      end
      default: return ALU_OE | A_W | FLAG_W
                      | ((op == 4'h2) ? ALU_SUB : 15'h0);
    endcase
  endfunction

  bit midle = 1;
  bit mhalt = 0;
  int mk = 0;
  int fetch_cnt = 0;
  int fetch_done = 0;
  logic [15:0] prog[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      midle <= 1; mhalt <= 0; mk <= 0;
    end else if (mhalt) begin
    end else if (midle) begin
      if (run) begin midle <= 0; mk <= 0; end
    end else if (mk == ilen(ir_out[15:12]) - 1) begin
      if (ir_out[15:12] == 4'hF) mhalt <= 1;
      else if (run) mk <= 0;
      else midle <= 1;
    end else begin
      if (mk == 1) fetch_cnt <= fetch_cnt + 1;
      mk <= mk + 1;
    end
  end

  // RAM stand-in: new instruction visible from T2 on
  always @(posedge clk) begin
    #1;
    if (fetch_cnt != fetch_done) begin
      fetch_done = fetch_cnt;
      if (prog.size() > 0) ir_out = prog.pop_front();
      else begin
        ir_out = 16'($urandom);
        if (ir_out[15:12] == 4'hF) ir_out[15:12] = 4'hE;
      end
    end
  end

  always @(posedge clk) begin
    logic [14:0] ev;
    int et;
    #2;
    ev = (midle || mhalt) ? 15'h0
         : exp_vec(mk, ir_out[15:12], zero_flag);
    et = midle ? 0 : mhalt ? 7 : mk + 1;
    chk("model_strobes", strobes, ev);
    chk("model_tstate", t_state, et);
    chk("model_halted", halted, mhalt);
    n_cmp++;
    if (!$onehot0({pc_oe, ram_oe, ir_oe, a_oe, alu_oe})) begin
      n_bad++;
      $display("FAIL bus_exclusive: got %b want onehot0",
               {pc_oe, ram_oe, ir_oe, a_oe, alu_oe});
    end
  end

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit got_halt;
    rst = 1; run = 0; ir_out = 16'h0; zero_flag = 0;
    prog.push_back(16'h0123);
    prog.push_back(16'h402A);
    prog.push_back(16'h1055);
    prog.push_back(16'h2056);
    prog.push_back(16'h6010);
    prog.push_back(16'h6010);
    prog.push_back(16'h1055);
    nxt(2);
    chk("rst_tstate", t_state, 0);
    chk("rst_strobes", strobes, 0);
    chk("rst_halted", halted, 0);
    rst = 0; run = 1;
    nxt(4);
    chk("lda_t3_state", t_state, 4);
    chk("lda_t3_strobes", strobes, RAM_OE | A_W);
    #2 rst = 1;
    #1;
    chk("async_rst_tstate", t_state, 0);
    chk("async_rst_strobes", strobes, 0);
    nxt(1);
    rst = 0;
    nxt(1);
    chk("ldi_t0_state", t_state, 1);
    chk("ldi_t0_strobes", strobes, PC_OE | MAR_W);
    nxt(1);
    chk("ldi_t1_strobes", strobes, RAM_OE | IR_W | PC_INC);
    nxt(1);
    chk("ldi_t2_strobes", strobes, IR_OE | A_W);
    nxt(1);
    chk("ldi_len3", t_state, 1);
    nxt(4);
    chk("add_t4_state", t_state, 5);
    chk("add_t4_strobes", strobes, ALU_OE | A_W | FLAG_W);
    nxt(5);
    chk("sub_t4_strobes", strobes,
        ALU_OE | A_W | FLAG_W | ALU_SUB);
    nxt(1);
    chk("sub_len5", t_state, 1);
    nxt(2);
    chk("jz_nz_strobes", strobes, 0);
    zero_flag = 1;
    nxt(1);
    chk("jz_nz_len3", t_state, 1);
    nxt(2);
    chk("jz_z_strobes", strobes, IR_OE | PC_LD);
    zero_flag = 0;
    nxt(1);
    chk("jz_z_len3", t_state, 1);
    nxt(3);
    chk("add2_t3_state", t_state, 4);
    run = 0;
    nxt(1);
    chk("runlow_t4_state", t_state, 5);
    chk("runlow_t4_strobes", strobes, ALU_OE | A_W | FLAG_W);
    nxt(1);
    chk("runlow_idle", t_state, 0);
    nxt(1);
    chk("runlow_stay_idle", t_state, 0);
    run = 1;
    nxt(1);
    chk("resume_t0", t_state, 1);
    for (int i = 0; i < 3000; i++) begin
      nxt(1);
      zero_flag = 1'($urandom);
      run = ($urandom_range(0, 9) != 0);
    end
    nxt(1);
    run = 1;
    prog.push_back(16'hF000);
    got_halt = 0;
    for (int i = 0; i < 30 && !got_halt; i++) begin
      nxt(1);
      if (halted) got_halt = 1;
    end
    n_cmp++;
    if (!got_halt) begin
      n_bad++;
      $display("FAIL hlt_timeout: got halted=0 want 1");
    end
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom);
      nxt(1);
      chk("halt_hold", halted, 1);
      chk("halt_strobes", strobes, 0);
      chk("halt_tstate", t_state, 7);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
